// File: rtl/stall_ctrl.sv
// Hazard/stall controller: Tuse/Tnew dependency stalls plus a mult/div busy tracker.
// Drives PC/F-D/D-E/E-M register controls and keeps a saturating stall-cycle count.
module stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_tnew,
    input  logic        D_is_md,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_flush,
    output logic        em_en,
    output logic        em_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cnt
);

    // state | meaning
    // IDLE  | mult/div unit free, waiting for E_md_start
    // BUSY  | operation in flight, cnt holds remaining busy cycles
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             data_stall;
    logic             md_stall;
    logic             stall;

    function automatic logic hazard(input logic [4:0] src, input logic [1:0] tuse,
                                    input logic [4:0] wa, input logic [1:0] tnew);
        return (src != 5'd0) && (src == wa) && (tnew > tuse);
    endfunction

    always_comb begin
        data_stall = hazard(D_rs, D_tuse_rs, E_wa, E_tnew)
                   | hazard(D_rs, D_tuse_rs, M_wa, M_tnew)
                   | hazard(D_rt, D_tuse_rt, E_wa, E_tnew)
                   | hazard(D_rt, D_tuse_rt, M_wa, M_tnew);
    end

    assign md_busy  = (state == BUSY);
    assign md_done  = md_busy && (cnt == ONE);
    assign md_stall = D_is_md && (md_busy || E_md_start);
    assign stall    = data_stall || md_stall;

    assign pc_en    = ~stall;
    assign fd_en    = ~stall;
    assign de_flush = stall;
    assign em_en    = 1'b1;
    assign em_flush = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (E_md_start) begin
                        state <= BUSY;
                        cnt   <= E_md_div ? DIV_LD : MULT_LD;
                    end
                end
                BUSY: begin
                    cnt <= cnt - ONE;
                    if (cnt == ONE) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= 32'd0;
        else if (stall && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end

    // A new mult/div launch can only reach E once the unit is free.
    a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset)
        !(md_busy && E_md_start));

endmodule

// File: tb/tb_stall_ctrl.sv
// Randomized + directed bench for stall_ctrl against a cycle-count reference model.
module tb_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_wa, M_wa;
    logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic        D_is_md, E_md_start, E_md_div;
    logic        pc_en, fd_en, de_flush, em_en, em_flush, md_busy, md_done;
    logic [31:0] stall_cnt;

    int nchecks = 0;
    int nerrors = 0;

    // Reference model: edge counter, edge index at which the unit frees up, stall total.
    longint cyc = 0;
    longint busy_end = 0;
    longint m_cnt = 0;

    stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
        .D_is_md(D_is_md), .E_md_start(E_md_start), .E_md_div(E_md_div),
        .pc_en(pc_en), .fd_en(fd_en), .de_flush(de_flush), .em_en(em_en),
        .em_flush(em_flush), .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return cyc < busy_end;
    endfunction

    function automatic bit m_data_stall();
        logic [4:0] src  [2];
        logic [1:0] tuse [2];
        logic [4:0] wa   [2];
        logic [1:0] tnew [2];
        bit s = 0;
        src[0] = D_rs; tuse[0] = D_tuse_rs; src[1] = D_rt; tuse[1] = D_tuse_rt;
        wa[0]  = E_wa; tnew[0] = E_tnew;    wa[1]  = M_wa; tnew[1] = M_tnew;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                if (src[i] != 0 && src[i] == wa[j] && int'(tnew[j]) > int'(tuse[i])) s = 1;
        return s;
    endfunction

    function automatic bit m_stall();
        return m_data_stall() || (D_is_md && (m_busy() || E_md_start));
    endfunction

    task automatic model_edge();
        bit st, bz;
        st = m_stall();
        bz = m_busy();
        cyc++;
        if (reset) begin
            busy_end = 0;
            m_cnt    = 0;
        end else begin
            if (st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (E_md_start && !bz) busy_end = cyc + (E_md_div ? DIV_N : MULT_N);
        end
    endtask

    task automatic check_all();
        bit st;
        st = m_stall();
        check("pc_en",     {31'd0, pc_en},    {31'd0, !st});
        check("fd_en",     {31'd0, fd_en},    {31'd0, !st});
        check("de_flush",  {31'd0, de_flush}, {31'd0, st});
        check("em_en",     {31'd0, em_en},    32'd1);
        check("em_flush",  {31'd0, em_flush}, 32'd0);
        check("md_busy",   {31'd0, md_busy},  {31'd0, m_busy()});
        check("md_done",   {31'd0, md_done},  {31'd0, (busy_end - cyc) == 1});
        check("stall_cnt", stall_cnt,         m_cnt[31:0]);
    endtask

    // Inputs are already applied at a negedge; check, clock once, return at next negedge.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        D_rs = 0; D_rt = 0; D_tuse_rs = 3; D_tuse_rt = 3;
        E_wa = 0; E_tnew = 0; M_wa = 0; M_tnew = 0;
        D_is_md = 0; E_md_start = 0; E_md_div = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_pc_en", {31'd0, pc_en}, 32'd1);
        check("rst_de_flush", {31'd0, de_flush}, 32'd0);
        check("rst_md_busy", {31'd0, md_busy}, 32'd0);
        check("rst_md_done", {31'd0, md_done}, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        step();

        // 1: E-stage dependency stall
        D_rs = 5; D_tuse_rs = 0; E_wa = 5; E_tnew = 1;
        #1;
        check("t1_pc_en", {31'd0, pc_en}, 32'd0);
        check("t1_fd_en", {31'd0, fd_en}, 32'd0);
        check("t1_de_flush", {31'd0, de_flush}, 32'd1);
        step();
        check("t1_stall_cnt", stall_cnt, 32'd1);

        // 2: register 0 and satisfied Tuse do not stall
        idle_inputs();
        D_rs = 0; E_wa = 0; E_tnew = 2; D_tuse_rs = 0;
        #1;
        check("t2_r0_pc_en", {31'd0, pc_en}, 32'd1);
        step();
        D_rt = 7; M_wa = 7; M_tnew = 1; D_tuse_rt = 1;
        #1;
        check("t2_eq_pc_en", {31'd0, pc_en}, 32'd1);
        step();

        // 3: mult busy window
        idle_inputs();
        E_md_start = 1; E_md_div = 0;
        step();
        E_md_start = 0;
        for (int i = 1; i <= MULT_N; i++) begin
            #1;
            check("t3_busy", {31'd0, md_busy}, 32'd1);
            check("t3_done", {31'd0, md_done}, {31'd0, i == MULT_N});
            step();
        end
        check("t3_busy_end", {31'd0, md_busy}, 32'd0);

        // 4: div start with a dependent md instruction held in D
        E_md_start = 1; E_md_div = 1; D_is_md = 1;
        step();
        E_md_start = 0;
        for (int i = 1; i <= DIV_N; i++) begin
            #1;
            check("t4_stall", {31'd0, de_flush}, 32'd1);
            step();
        end
        #1;
        check("t4_clear", {31'd0, de_flush}, 32'd0);
        step();

        // 5: reset on the 3rd busy cycle of a div
        idle_inputs();
        E_md_start = 1; E_md_div = 1;
        step();
        E_md_start = 0;
        step();
        step();
        reset = 1;
        step();
        reset = 0;
        #1;
        check("t5_busy", {31'd0, md_busy}, 32'd0);
        check("t5_done", {31'd0, md_done}, 32'd0);
        check("t5_stall_cnt", stall_cnt, 32'd0);
        step();

        // 6: saturation near the top of the counter
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        m_cnt = 64'hFFFF_FFFE;
        D_rs = 9; D_tuse_rs = 0; E_wa = 9; E_tnew = 2;
        for (int i = 0; i < 3; i++) step();
        check("t6_sat", stall_cnt, 32'hFFFF_FFFF);
        reset = 1;
        step();
        reset = 0;

        // Random phase: small register space to provoke collisions
        for (int n = 0; n < 600; n++) begin
            D_rs = 5'($urandom_range(0, 3));   D_rt = 5'($urandom_range(0, 3));
            E_wa = 5'($urandom_range(0, 3));   M_wa = 5'($urandom_range(0, 3));
            D_tuse_rs = 2'($urandom_range(0, 3)); D_tuse_rt = 2'($urandom_range(0, 3));
            E_tnew = 2'($urandom_range(0, 3));    M_tnew = 2'($urandom_range(0, 3));
            D_is_md = ($urandom_range(0, 2) == 0);
            E_md_div = 1'($urandom_range(0, 1));
            E_md_start = !m_busy() && ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
